// File: rtl/dadda_mac.sv
// dadda_mac: streaming unsigned dot-product engine.
// Each accepted 4-bit operand pair is multiplied by a 4x4 Dadda multiplier.
// The product is registered and then summed into an accumulator. After LEN
// pairs the result is presented on acc with a valid/ready handshake.

// dadda_mul4: 4x4 unsigned Dadda multiplier, purely combinational.
// Column heights 1,2,3,4,3,2,1 reduce to 3 (stage 1) and then to 2 (stage 2).
// A ripple carry-propagate add forms the final 8-bit product.
module dadda_mul4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);

  // w_pp[i][j] = a[j] & b[i], weight i+j
  logic [3:0] w_pp [4];

  logic w_s1, w_c1, w_s2, w_c2;
  logic w_s3, w_c3, w_s4, w_c4, w_s5, w_c5, w_s6, w_c6;
  logic [6:0] w_row_x;
  logic [6:0] w_row_y;

  // partial-product AND array
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        w_pp[i][j] = i_a[j] & i_b[i];
      end
    end
  end

  // stage 1 (target height 3): half adders in columns 3 and 4
  assign w_s1 = w_pp[0][3] ^ w_pp[1][2];
  assign w_c1 = w_pp[0][3] & w_pp[1][2];
  assign w_s2 = w_pp[1][3] ^ w_pp[2][2];
  assign w_c2 = w_pp[1][3] & w_pp[2][2];

  // stage 2 (target height 2): HA in column 2, full adders in columns 3..5
  assign w_s3 = w_pp[0][2] ^ w_pp[1][1];
  assign w_c3 = w_pp[0][2] & w_pp[1][1];

  assign w_s4 = w_s1 ^ w_pp[2][1] ^ w_pp[3][0];
  assign w_c4 = (w_s1 & w_pp[2][1]) | (w_s1 & w_pp[3][0]) | (w_pp[2][1] & w_pp[3][0]);

  assign w_s5 = w_s2 ^ w_pp[3][1] ^ w_c1;
  assign w_c5 = (w_s2 & w_pp[3][1]) | (w_s2 & w_c1) | (w_pp[3][1] & w_c1);

  assign w_s6 = w_pp[2][3] ^ w_pp[3][2] ^ w_c2;
  assign w_c6 = (w_pp[2][3] & w_pp[3][2]) | (w_pp[2][3] & w_c2) | (w_pp[3][2] & w_c2);

  // two remaining rows, bit k has weight k
  assign w_row_x = {w_pp[3][3], w_s6, w_s5, w_s4, w_s3, w_pp[0][1], w_pp[0][0]};
  assign w_row_y = {w_c6, w_c5, w_c4, w_c3, w_pp[0][2] & 1'b0 | w_pp[2][0], w_pp[1][0], 1'b0};

  // final carry-propagate addition
  assign o_p = {1'b0, w_row_x} + {1'b0, w_row_y};

endmodule

module dadda_mac #(
  parameter int LEN   = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_HOLD
  } state_t;

  localparam logic [4:0] LEN_C = 5'(LEN);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       w_op;
  logic             w_accept;
  logic             w_handshake;
  logic             w_last;
  logic [7:0]       r_p;
  logic             r_pv;
  logic [4:0]       r_cnt;
  logic [ACC_W-1:0] r_acc;

  dadda_mul4 u_mul (
    .i_a (a),
    .i_b (b),
    .o_p (w_op)
  );

  assign w_accept    = in_valid && in_ready;
  assign w_handshake = out_valid && out_ready;
  assign w_last      = w_accept && ((r_cnt + 5'd1) == LEN_C);
  assign acc         = r_acc;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (w_last)        w_state_nxt = ST_DRAIN;
        else if (w_accept) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        in_ready = 1'b1;
        if (w_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // product pipeline register; accumulation of the previous product
  // happens on the same edge that captures a new one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p  <= '0;
      r_pv <= 1'b0;
    end else begin
      if (w_accept) r_p <= w_op;
      r_pv <= w_accept;
    end
  end

  // accepted-pair counter and accumulator, cleared by the result handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_handshake) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else begin
      if (w_accept) r_cnt <= r_cnt + 5'd1;
      if (r_pv)     r_acc <= r_acc + ACC_W'(r_p);
    end
  end

endmodule

// File: tb/tb_dadda_mac.sv
// Directed bench for dadda_mac: three instances (LEN 4, 16, 1) share the
// operand bus; a select chooses which one receives in_valid and is observed.
module tb_dadda_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  a, b;
  logic        out_ready;
  int unsigned sel;

  logic        ir4, ir16, ir1, ov4, ov16, ov1;
  logic [11:0] acc4, acc16, acc1;
  logic        obs_ir, obs_ov;
  logic [11:0] obs_acc;

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned exp_sum;
  int unsigned scb[$];

  always #5 clk = ~clk;

  dadda_mac #(.LEN(4), .ACC_W(12)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 0), .in_ready(ir4),
    .a(a), .b(b), .out_valid(ov4), .out_ready(out_ready), .acc(acc4));
  dadda_mac #(.LEN(16), .ACC_W(12)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(ir16),
    .a(a), .b(b), .out_valid(ov16), .out_ready(out_ready), .acc(acc16));
  dadda_mac #(.LEN(1), .ACC_W(12)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2), .in_ready(ir1),
    .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready), .acc(acc1));

  always_comb begin
    obs_ir  = ir4;
    obs_ov  = ov4;
    obs_acc = acc4;
    if (sel == 1) begin
      obs_ir = ir16; obs_ov = ov16; obs_acc = acc16;
    end else if (sel == 2) begin
      obs_ir = ir1; obs_ov = ov1; obs_acc = acc1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // drive a pair now and let the next rising edge take it
  task automatic put(input logic [3:0] va, input logic [3:0] vb);
    a = va; b = vb; in_valid = 1'b1;
    #1 chk("in_ready_on_send", 32'(obs_ir), 1);
    exp_sum += int'(va) * int'(vb);
    @(posedge clk);
  endtask

  task automatic send(input logic [3:0] va, input logic [3:0] vb);
    @(negedge clk);
    put(va, vb);
  endtask

  task automatic bubble();
    @(negedge clk);
    in_valid = 1'b0;
    a = 4'($urandom); b = 4'($urandom);
  endtask

  // close the vector: push its expected sum, then wait (bounded) for out_valid
  task automatic expect_result();
    int lat;
    int unsigned e;
    scb.push_back(exp_sum);
    exp_sum = 0;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!obs_ov && lat < 20);
    chk("out_valid_seen", 32'(obs_ov), 1);
    chk("out_valid_latency", 32'(lat), 2);
    e = scb.pop_front();
    chk("acc_result", 32'(obs_acc), e);
    chk("in_ready_in_hold", 32'(obs_ir), 0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_out_valid"}, 32'(obs_ov), 0);
    chk({tag, "_in_ready"}, 32'(obs_ir), 1);
    chk({tag, "_acc"}, 32'(obs_acc), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1; sel = 0;
    exp_sum = 0;

    // reset values for all three instances
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1 check_idle("reset");
    end
    sel = 0;
    @(negedge clk) rst = 1'b0;

    // ignored inputs: operands toggle with in_valid low
    repeat (3) bubble();
    chk("idle_acc_after_toggles", 32'(obs_acc), 0);

    // basic sum, back-to-back, out_ready high
    send(15, 14); send(10, 8); send(3, 9); send(6, 15);
    expect_result();
    @(negedge clk);
    check_idle("after_handshake");

    // backpressure with in_valid raised during HOLD
    out_ready = 1'b0;
    send(15, 14); send(10, 8); send(3, 9); send(6, 15);
    expect_result();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 4'($urandom); b = 4'($urandom);
      #1;
      chk("hold_out_valid", 32'(obs_ov), 1);
      chk("hold_in_ready", 32'(obs_ir), 0);
      chk("hold_acc", 32'(obs_acc), 407);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_idle("after_backpressure");

    // reset mid-operation discards the partial sum
    send(15, 15); send(15, 15);
    @(negedge clk);
    in_valid = 1'b0;
    chk("partial_acc", 32'(obs_acc), 225);
    #2 rst = 1'b1;
    #1 check_idle("async_reset");
    @(negedge clk);
    rst = 1'b0;
    exp_sum = 0;
    put(10, 13); send(12, 9); send(1, 1); send(0, 7);
    expect_result();
    @(negedge clk);
    check_idle("after_reset_vector");

    // LEN=16, maximum operands, bubble between pairs
    sel = 1;
    for (int i = 0; i < 16; i++) begin
      send(15, 15);
      if (i < 15) bubble();
    end
    expect_result();

    // LEN=1, next pair accepted on the cycle after the handshake
    sel = 2;
    send(12, 9);
    expect_result();
    @(negedge clk);
    check_idle("len1_handshake");
    put(3, 9);
    expect_result();
    @(negedge clk);
    check_idle("len1_done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
